// File: rtl/adc_serial_rx.sv
// Serial receiver for a 16-bit SPI-style ADC frame: drives adc_cs_n/adc_sclk from the
// divider strobes, shifts in 16 bits MSB first and presents a DATA_W-bit sample.
module adc_serial_rx #(
  parameter int HALF_CLKS = 66,
  parameter int DATA_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_tick,
  input  logic              frame_tick,
  input  logic              sdata,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              frame_err,
  output logic [1:0]        dbg_state
);

  localparam int FRAME_BITS = 16;
  localparam int HW         = $clog2(HALF_CLKS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  sdata_meta, sdata_sync;
  logic [FRAME_BITS-1:0] shift;
  logic [4:0]            bit_cnt;
  logic [HW-1:0]         half_cnt;
  logic                  fall_req;
  logic                  frame_start, rise_now, bit_tick;

  assign frame_start = sclk_tick & frame_tick;
  // rise_now marks the end of a low half-period; capture happens on that same edge.
  assign rise_now    = (state == ACTIVE) && !adc_sclk && (half_cnt == '0);
  // Ticks while a half-period is still counting or a fall is pending are dropped.
  assign bit_tick    = (state == ACTIVE) && sclk_tick && adc_sclk && !fall_req;
  assign dbg_state   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdata_meta <= 1'b0;
      sdata_sync <= 1'b0;
    end else begin
      sdata_meta <= sdata;
      sdata_sync <= sdata_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = ACTIVE;
      ACTIVE:  if (rise_now && bit_cnt == 5'(FRAME_BITS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // sample_valid is a one-clk strobe with no backpressure: the consumer must take
  // sample/frame_err on the cycle sample_valid is high; both then hold until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      shift        <= '0;
      bit_cnt      <= '0;
      half_cnt     <= '0;
      fall_req     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            adc_cs_n <= 1'b0;
            bit_cnt  <= '0;
            shift    <= '0;
            fall_req <= 1'b1;
          end
        end
        ACTIVE: begin
          if (fall_req) begin
            adc_sclk <= 1'b0;
            half_cnt <= HW'(HALF_CLKS - 1);
            fall_req <= 1'b0;
          end else if (rise_now) begin
            adc_sclk <= 1'b1;
            shift    <= {shift[FRAME_BITS-2:0], sdata_sync};
            bit_cnt  <= bit_cnt + 5'd1;
          end else if (!adc_sclk) begin
            half_cnt <= half_cnt - HW'(1);
          end else if (bit_tick) begin
            fall_req <= 1'b1;
          end
        end
        DONE: begin
          adc_cs_n     <= 1'b1;
          sample       <= shift[DATA_W-1:0];
          frame_err    <= |shift[FRAME_BITS-1:DATA_W];
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_rx.sv
// Directed bench for adc_serial_rx: divider strobes and an ADC shift-out model are
// stepped cycle by cycle; expected samples are queued at frame start and popped on sample_valid.
module tb_adc_serial_rx;
  localparam int P        = 133;
  localparam int HALF     = 66;
  localparam int DW       = 12;
  localparam int DONE_LAT = 2 + 15 * P + HALF;

  logic          clk = 1'b0;
  logic          rst, sclk_tick, frame_tick, sdata;
  logic          adc_cs_n, adc_sclk, sample_valid, frame_err;
  logic [DW-1:0] sample;
  logic [1:0]    dbg_state;

  int vectors = 0, miscompares = 0;
  int cyc = 0, div_cnt = 5, tick_idx = 0;
  bit spur_en = 1'b0;
  logic [15:0] cur_word = '0;
  int c_start = 0, falls = 0, adc_bit = 0, low_len = 0, valid_cnt = 0, last_valid_cyc = 0;
  logic prev_sclk = 1'b1;
  logic [DW:0] exp_q[$];
  int          exp_cyc_q[$];

  adc_serial_rx #(.HALF_CLKS(HALF), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .sclk_tick(sclk_tick), .frame_tick(frame_tick), .sdata(sdata),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample(sample), .sample_valid(sample_valid),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive divider strobes, take the edge, then observe pins and outputs.
  task automatic step();
    logic [DW:0] e;
    int          ec;
    sclk_tick  = (div_cnt == 0);
    frame_tick = (div_cnt == 0) && (tick_idx == 0 || (spur_en && tick_idx == 9));
    @(posedge clk);
    cyc++;
    if (sclk_tick) tick_idx = (tick_idx == 16) ? 0 : tick_idx + 1;
    div_cnt = (div_cnt == P - 1) ? 0 : div_cnt + 1;
    #1;
    if (adc_cs_n) check("sclk_high_when_cs_high", adc_sclk, 1);
    if (!adc_sclk) low_len++;
    if (prev_sclk && !adc_sclk) begin
      low_len = 1;
      if (!adc_cs_n) begin
        check("fall_time", cyc, c_start + 1 + falls * P);
        falls++;
        if (adc_bit < 16) begin
          sdata = cur_word[15 - adc_bit];
          adc_bit++;
        end
      end
    end
    if (!prev_sclk && adc_sclk) begin
      check("sclk_low_time", low_len, HALF);
      low_len = 0;
    end
    prev_sclk = adc_sclk;
    if (sample_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("valid_without_frame", sample_valid, 0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("sample", sample, e[DW-1:0]);
        check("frame_err", frame_err, e[DW]);
        check("cs_n_rise_with_valid", adc_cs_n, 1);
        check("valid_time", cyc, ec);
      end
    end
  endtask

  // mode 0: clean frame, 1: reset after the 7th fall, 2: extra frame start at bit 9.
  task automatic run_frame(input logic [15:0] word, input int mode);
    bit did_rst;
    int rst_hold;
    did_rst  = 1'b0;
    rst_hold = 0;
    while (!(div_cnt == 0 && tick_idx == 0)) step();
    cur_word  = word;
    c_start   = cyc + 1;
    falls     = 0;
    adc_bit   = 0;
    valid_cnt = 0;
    exp_q.push_back({|word[15:DW], word[DW-1:0]});
    exp_cyc_q.push_back(c_start + DONE_LAT);
    spur_en = (mode == 2);
    for (int k = 0; k < 17 * P; k++) begin
      step();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end
      if (mode == 1 && falls == 7 && !did_rst) begin
        did_rst = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_frame_err", frame_err, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        prev_sclk = 1'b1;
        low_len   = 0;
        rst_hold  = 4;
      end
    end
    spur_en = 1'b0;
    if (mode == 1) begin
      check("falls_before_reset", falls, 7);
      check("no_valid_after_reset", valid_cnt, 0);
      check("sample_cleared", sample, 0);
    end else begin
      check("fall_count", falls, 16);
      check("valid_pulses", valid_cnt, 1);
      check("sample_hold", sample, word[DW-1:0]);
      check("frame_err_hold", frame_err, |word[15:DW]);
    end
  endtask

  initial begin
    int t1;
    rst        = 1'b1;
    sclk_tick  = 1'b0;
    frame_tick = 1'b0;
    sdata      = 1'b0;
    repeat (4) step();
    check("reset_cs_n", adc_cs_n, 1);
    check("reset_sclk", adc_sclk, 1);
    check("reset_sample", sample, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_frame_err", frame_err, 0);
    rst = 1'b0;

    run_frame(16'h0A5C, 0);
    run_frame(16'h0FFF, 0);
    t1 = last_valid_cyc;
    run_frame(16'h0000, 0);
    check("valid_spacing", last_valid_cyc - t1, 17 * P);
    run_frame(16'h8123, 0);
    run_frame(16'h0456, 0);
    run_frame(16'h0ABC, 1);
    run_frame(16'h0321, 0);
    run_frame(16'h0777, 2);
    for (int i = 0; i < 3; i++) run_frame(16'($urandom_range(0, 65535)), 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
